clk_step_ctrl: RTL and testbench
================================

// Module: clk_step_ctrl
// PURPOSE
//  Synthesizable run/step/halt controller for the slow CPU clock in the single-cycle/multi-cycle CPU labs.
//  Derives a SlowClk square wave from Clk: T_OFF cycles low, then T_ON cycles high.
//  Also emits a one-cycle CpuEn pulse on each rising phase.
//  Sits between the board buttons/switches (already synchronised) and the CPU clock-enable input.
//  Three modes: free-run, single period per Step press, immediate abort on Halt.
// PARAMETERS
//  T_OFF  10  low-phase length in Clk cycles (>=1)
//  T_ON   10  high-phase length in Clk cycles (>=1)
//  CNT_W  32  width of completed-period counter Cycles
// PORTS
//  Clk      in   1      system clock, all logic on posedge
//  Rst_n    in   1      synchronous reset, active low
//  Run      in   1      level: free-run while high
//  Step     in   1      rising edge requests one full period (level may be held)
//  Halt     in   1      level: abort to idle immediately, highest priority
//  SlowClk  out  1      registered divided clock
//  CpuEn    out  1      registered pulse, high in the first cycle SlowClk is high
//  Busy     out  1      registered; high while state != S_IDLE
//  Cycles   out  CNT_W  completed periods, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (Rst_n=0 at posedge): state=S_IDLE, phase cnt=0, SlowClk=0, CpuEn=0, Busy=0, Cycles=0, Step_q=0.
//  States: S_IDLE, S_RUN, S_STEP. Phase flag = SlowClk (0 = low phase, 1 = high phase).
//  Step edge: stp = Step & ~Step_q. Step_q is updated every cycle, in all states.
//  S_IDLE transitions:
//   - Halt: stay in S_IDLE.
//   - else Run: go to S_RUN.
//   - else stp: go to S_STEP.
//   - On entry to S_RUN/S_STEP: cnt=0, SlowClk=0.
//  Low phase (S_RUN/S_STEP, SlowClk=0): cnt increments each cycle.
//   - At cnt==T_OFF-1: SlowClk<=1, CpuEn<=1, cnt<=0.
//   - CpuEn is high exactly one cycle, the first high cycle.
//  High phase (SlowClk=1): cnt increments each cycle.
//   - At cnt==T_ON-1: SlowClk<=0, cnt<=0, Cycles<=Cycles+1 (period complete).
//   - After completion: S_STEP goes to S_IDLE; S_RUN goes to S_IDLE if Run==0, else starts the next low phase.
//  Latency: Run sampled high in S_IDLE at edge k means state=S_RUN after edge k; SlowClk is high after edge k+T_OFF.
//  Run falls during the low phase: go to S_IDLE next edge, SlowClk stays 0, no CpuEn, Cycles unchanged.
//  Run falls during the high phase: finish the high phase; SlowClk is never truncated.
//  Halt in any state, either phase:
//   - Next edge: state=S_IDLE, SlowClk=0, CpuEn=0, cnt=0.
//   - Cycles unchanged; a high phase may be truncated.
//   - Halt overrides a simultaneous period completion, so Cycles is not incremented.
//  Step rules:
//   - Step while in S_RUN or S_STEP is ignored and not queued.
//   - Holding Step high gives one period only.
//   - Run and stp in the same idle cycle: Run wins.
//   - In S_STEP, Run rising does not convert the step to a run.
//  Rst_n low mid-period: all registers return to reset values at that edge, regardless of other inputs.
//  Widths:
//   - cnt width PH_W = $clog2(max(T_ON,T_OFF)).
//   - Use a minimum of 1 bit for PH_W.
//   - Cycles is an unsigned wrap counter with no saturation.
//  Busy = (state != S_IDLE), registered with the state.
// STRUCTURE
//  clk_ctrl_pkg (shared header): state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_STEP=2'd2.
//   Also holds the helper function max2() used to size PH_W.
//  Sub-module rise_detect (1-bit Step_q register plus AND) produces stp; the rest is one FSM plus two counters.
// TESTING (T_OFF=2, T_ON=3, CNT_W=3)
//  1. Hold Rst_n=0 and Run=1 for 4 cycles -> all outputs 0.
//     Release -> SlowClk high 2 cycles after state=S_RUN, pattern 0,0,1,1,1 repeating, CpuEn on each first 1.
//  2. Step high for 6 cycles from S_IDLE -> exactly one period: SlowClk high 3 cycles, one CpuEn, Cycles=1, Busy falls.
//  3. Run for 4 periods, drop Run in the 2nd high cycle -> high phase completes (3 cycles), Cycles=4, S_IDLE.
//  4. Run, drop Run in low cycle 1 -> S_IDLE next edge, no CpuEn, Cycles unchanged.
//  5. Halt in the 2nd high cycle -> SlowClk=0 next edge, Cycles unchanged.
//     Step pressed while Halt is high -> no period starts.
//  6. Run for 9 periods -> Cycles wraps 7->0->1.
//     Rst_n pulsed mid-high-phase -> immediate reset values.

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the slow CPU clock run/step/halt controller:
// FSM state encoding and a constant helper used to size the phase counter.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_step_ctrl_rise_detect.sv
// Rising-edge detector for an already-synchronised level input.
// The history register tracks the input every cycle, whatever the consumer is doing.
module rise_detect (
    input  logic Clk,
    input  logic Rst_n,
    input  logic din,
    output logic rise
);

    logic din_q;
    logic din_d;

    always_comb begin
        din_d = din;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_d;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/step/halt controller producing the slow CPU clock (T_OFF low, T_ON high),
// a one-cycle CpuEn pulse at each rising phase and a wrapping completed-period count.
module clk_step_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int T_OFF = 10,
    parameter int T_ON  = 10,
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Run,
    input  logic             Step,
    input  logic             Halt,
    output logic             SlowClk,
    output logic             CpuEn,
    output logic             Busy,
    output logic [CNT_W-1:0] Cycles
);

    localparam int PH_MAX = max2(T_ON, T_OFF);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(T_OFF - 1);
    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(T_ON - 1);

    state_t            state_q, state_d;
    logic [PH_W-1:0]   cnt_q, cnt_d;
    logic              slow_q, slow_d;
    logic              cpu_en_q, cpu_en_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              stp;

    rise_detect u_step_edge (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .din   (Step),
        .rise  (stp)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        slow_d   = slow_q;
        cpu_en_d = 1'b0;
        cycles_d = cycles_q;

        if (Halt) begin
            // Abort wins over everything, including a period completing this cycle.
            state_d = S_IDLE;
            cnt_d   = '0;
            slow_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Run) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        slow_d  = 1'b0;
                    end else if (stp) begin
                        state_d = S_STEP;
                        cnt_d   = '0;
                        slow_d  = 1'b0;
                    end
                end
                S_RUN, S_STEP: begin
                    if (!slow_q) begin
                        if (state_q == S_RUN && !Run) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == OFF_LAST) begin
                            slow_d   = 1'b1;
                            cpu_en_d = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (cnt_q == ON_LAST) begin
                        // High phase is never cut short by Run dropping; only here do we leave.
                        slow_d   = 1'b0;
                        cnt_d    = '0;
                        cycles_d = cycles_q + 1'b1;
                        if (state_q == S_STEP || !Run) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    slow_d  = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            slow_q   <= 1'b0;
            cpu_en_q <= 1'b0;
            busy_q   <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            slow_q   <= slow_d;
            cpu_en_q <= cpu_en_d;
            busy_q   <= busy_d;
            cycles_q <= cycles_d;
        end
    end

    assign SlowClk = slow_q;
    assign CpuEn   = cpu_en_q;
    assign Busy    = busy_q;
    assign Cycles  = cycles_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl (T_OFF=2, T_ON=3, CNT_W=3): directed vector table,
// multi-cycle corner sequences, then random stimulus against a period-position model.
module tb_clk_step_ctrl;

    localparam int T_OFF  = 2;
    localparam int T_ON   = 3;
    localparam int CNT_W  = 3;
    localparam int PERIOD = T_OFF + T_ON;
    localparam int NVEC   = 40;

    logic             Clk = 1'b0;
    logic             Rst_n = 1'b0;
    logic             Run = 1'b0;
    logic             Step = 1'b0;
    logic             Halt = 1'b0;
    logic             SlowClk;
    logic             CpuEn;
    logic             Busy;
    logic [CNT_W-1:0] Cycles;

    int errors = 0;
    int checks = 0;

    clk_step_ctrl #(.T_OFF(T_OFF), .T_ON(T_ON), .CNT_W(CNT_W)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Run     (Run),
        .Step    (Step),
        .Halt    (Halt),
        .SlowClk (SlowClk),
        .CpuEn   (CpuEn),
        .Busy    (Busy),
        .Cycles  (Cycles)
    );

    always #5 Clk = ~Clk;

    // Reference model: mode plus position within the period (0..PERIOD-1).
    int m_mode = 0;   // 0 idle, 1 run, 2 step
    int m_pos  = 0;
    int m_cyc  = 0;
    bit m_prev_step = 1'b0;

    task automatic model_update();
        bit edge_seen;
        edge_seen = Step && !m_prev_step;
        m_prev_step = Rst_n ? Step : 1'b0;
        if (!Rst_n) begin
            m_mode = 0; m_pos = 0; m_cyc = 0;
        end else if (Halt) begin
            m_mode = 0; m_pos = 0;
        end else if (m_mode == 0) begin
            if (Run) begin
                m_mode = 1; m_pos = 0;
            end else if (edge_seen) begin
                m_mode = 2; m_pos = 0;
            end
        end else if (m_pos < T_OFF) begin
            if (m_mode == 1 && !Run) begin
                m_mode = 0; m_pos = 0;
            end else begin
                m_pos++;
            end
        end else begin
            m_pos++;
            if (m_pos == PERIOD) begin
                m_pos = 0;
                m_cyc = (m_cyc + 1) % (1 << CNT_W);
                if (m_mode == 2 || !Run) m_mode = 0;
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst_n, run, step, halt;
        logic       slow, en, busy;
        logic [2:0] cyc;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic setv(input int i, input logic r, input logic ru, input logic s, input logic h,
                        input logic sl, input logic e, input logic b, input logic [2:0] c);
        vecs[i].rst_n = r; vecs[i].run = ru; vecs[i].step = s; vecs[i].halt = h;
        vecs[i].slow = sl; vecs[i].en = e; vecs[i].busy = b; vecs[i].cyc = c;
    endtask

    initial begin
        // Reset held with Run high, then free-run 0,0,1,1,1
        for (int i = 0; i < 4; i++) setv(i, 0, 1, 0, 0, 0, 0, 0, 0);
        setv(4,  1, 1, 0, 0, 0, 0, 1, 0);
        setv(5,  1, 1, 0, 0, 0, 0, 1, 0);
        setv(6,  1, 1, 0, 0, 1, 1, 1, 0);
        setv(7,  1, 1, 0, 0, 1, 0, 1, 0);
        setv(8,  1, 1, 0, 0, 1, 0, 1, 0);
        setv(9,  1, 1, 0, 0, 0, 0, 1, 1);
        setv(10, 1, 1, 0, 0, 0, 0, 1, 1);
        setv(11, 1, 1, 0, 0, 1, 1, 1, 1);
        // Run dropped in high phase: high phase completes
        setv(12, 1, 0, 0, 0, 1, 0, 1, 1);
        setv(13, 1, 0, 0, 0, 1, 0, 1, 1);
        setv(14, 1, 0, 0, 0, 0, 0, 0, 2);
        setv(15, 1, 0, 0, 0, 0, 0, 0, 2);
        // Step held for 6 cycles: exactly one period
        setv(16, 1, 0, 1, 0, 0, 0, 1, 2);
        setv(17, 1, 0, 1, 0, 0, 0, 1, 2);
        setv(18, 1, 0, 1, 0, 1, 1, 1, 2);
        setv(19, 1, 0, 1, 0, 1, 0, 1, 2);
        setv(20, 1, 0, 1, 0, 1, 0, 1, 2);
        setv(21, 1, 0, 1, 0, 0, 0, 0, 3);
        setv(22, 1, 0, 0, 0, 0, 0, 0, 3);
        // Run dropped in first low cycle
        setv(23, 1, 1, 0, 0, 0, 0, 1, 3);
        setv(24, 1, 0, 0, 0, 0, 0, 0, 3);
        // Halt in second high cycle, then Step while halted
        setv(25, 1, 1, 0, 0, 0, 0, 1, 3);
        setv(26, 1, 1, 0, 0, 0, 0, 1, 3);
        setv(27, 1, 1, 0, 0, 1, 1, 1, 3);
        setv(28, 1, 1, 0, 0, 1, 0, 1, 3);
        setv(29, 1, 1, 0, 1, 0, 0, 0, 3);
        setv(30, 1, 0, 1, 1, 0, 0, 0, 3);
        setv(31, 1, 0, 1, 0, 0, 0, 0, 3);
        setv(32, 1, 0, 0, 0, 0, 0, 0, 3);
        // Halt coinciding with period completion: no increment
        setv(33, 1, 1, 0, 0, 0, 0, 1, 3);
        setv(34, 1, 1, 0, 0, 0, 0, 1, 3);
        setv(35, 1, 1, 0, 0, 1, 1, 1, 3);
        setv(36, 1, 1, 0, 0, 1, 0, 1, 3);
        setv(37, 1, 1, 0, 0, 1, 0, 1, 3);
        setv(38, 1, 1, 0, 1, 0, 0, 0, 3);
        // Run and Step edge together in idle: Run wins, Step not queued
        setv(39, 1, 1, 1, 0, 0, 0, 1, 3);

        @(posedge Clk);
        #1;
        for (int i = 0; i < NVEC; i++) begin
            Rst_n = vecs[i].rst_n; Run = vecs[i].run; Step = vecs[i].step; Halt = vecs[i].halt;
            tick();
            $display("vec %0d: in rst_n=%0b run=%0b step=%0b halt=%0b -> slow=%0b en=%0b busy=%0b cyc=%0d",
                     i, Rst_n, Run, Step, Halt, SlowClk, CpuEn, Busy, Cycles);
            chk($sformatf("vec%0d_slow", i), int'(SlowClk), int'(vecs[i].slow));
            chk($sformatf("vec%0d_en", i),   int'(CpuEn),   int'(vecs[i].en));
            chk($sformatf("vec%0d_busy", i), int'(Busy),    int'(vecs[i].busy));
            chk($sformatf("vec%0d_cyc", i),  int'(Cycles),  int'(vecs[i].cyc));
        end

        // Four periods, Run dropped in the 2nd high cycle of the 4th
        begin
            int hi4 = 0;
            bit done = 1'b0;
            Run = 0; Step = 0; Halt = 0; Rst_n = 0;
            tick();
            Rst_n = 1; Run = 1;
            for (int i = 0; i < 60 && !done; i++) begin
                tick();
                if (SlowClk && Cycles == 3'd3) begin
                    hi4++;
                    if (hi4 == 2) Run = 0;
                end
                if (!Busy) done = 1'b1;
            end
            $display("seq run4: cycles=%0d last_high=%0d busy=%0b", Cycles, hi4, Busy);
            chk("run4_terminated", int'(done), 1);
            chk("run4_cycles", int'(Cycles), 4);
            chk("run4_last_high_len", hi4, T_ON);
            chk("run4_slow_low", int'(SlowClk), 0);
        end

        // Nine periods: Cycles wraps, then reset mid high phase
        Rst_n = 0; Run = 0;
        tick();
        Rst_n = 1; Run = 1;
        tick();
        for (int p = 1; p <= 9; p++) begin
            for (int k = 0; k < PERIOD; k++) tick();
            $display("seq wrap: period %0d cycles=%0d", p, Cycles);
            chk($sformatf("wrap_p%0d", p), int'(Cycles), p % (1 << CNT_W));
        end
        for (int k = 0; k < T_OFF + 1; k++) tick();
        chk("pre_rst_slow", int'(SlowClk), 1);
        Rst_n = 0;
        tick();
        $display("seq midreset: slow=%0b en=%0b busy=%0b cyc=%0d", SlowClk, CpuEn, Busy, Cycles);
        chk("midrst_slow", int'(SlowClk), 0);
        chk("midrst_en", int'(CpuEn), 0);
        chk("midrst_busy", int'(Busy), 0);
        chk("midrst_cyc", int'(Cycles), 0);

        // Random stimulus against the model
        Rst_n = 1; Run = 0; Step = 0; Halt = 0;
        for (int i = 0; i < 2500; i++) begin
            Rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 9) == 0) Run = ~Run;
            if ($urandom_range(0, 3) == 0) Step = ~Step;
            Halt = ($urandom_range(0, 24) == 0);
            tick();
            chk("rnd_slow", int'(SlowClk), int'(m_mode != 0 && m_pos >= T_OFF));
            chk("rnd_en",   int'(CpuEn),   int'(m_mode != 0 && m_pos == T_OFF));
            chk("rnd_busy", int'(Busy),    int'(m_mode != 0));
            chk("rnd_cyc",  int'(Cycles),  m_cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
